bus_select_decoder: RTL and testbench
=====================================

Name: bus_select_decoder

Overview:
- Drives the datapath bus from the other end of the 5-bit bus select code used by the bus-source encoder.
- Accepts a select code through a valid/ready handshake and decodes it into a registered one-hot drive-enable vector for the 32 bus sources.
- Enforces a programmable break-before-make gap, so two sources never drive the bus in the same cycle.
- Rejects reserved codes.

Parameters:
- GAP_CYCLES, 1, number of all-zero drive cycles inserted when switching between two different sources. Legal range 0..15; 0 means a direct switch.
- VALID_MASK, 32'h00FF_FFFF, bit n set means code n is legal. Codes 24..31 are reserved by default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sel_valid  input  1  a select code is offered this cycle.
- select_signals  input  5  offered source code.
- sel_release  input  1  stop driving the bus and return to IDLE.
- sel_ready  output  1  the block accepts select_signals this cycle.
- drive_en  output  32  registered one-hot source enable, bits mapped by code:
  - 0-15: r0-r15
  - 16: HI
  - 17: LO
  - 18: Z_HI
  - 19: Z_LO
  - 20: PC
  - 21: MDR
  - 22: inPort
  - 23: Cout
  - 24-31: reserved
- cur_sel  output  5  registered code currently driving, or pending after a gap.
- busy  output  1  high while in GAP.
- sel_err  output  1  one-cycle pulse: a reserved or masked code was offered and accepted.

Behaviour:
- Reset (reset=1 at a clock edge):
  - State goes to IDLE.
  - drive_en=0, cur_sel=0, busy=0, sel_err=0, gap counter cleared.
  - sel_ready=0 while reset is high.
  - Reset mid-GAP or mid-DRIVE aborts the operation; no pending code survives.
- Handshake:
  - Transfer occurs on an edge where sel_valid & sel_ready.
  - sel_ready = !reset & !sel_release & (state != GAP), combinational.
  - Upstream must hold select_signals stable while sel_valid is high and sel_ready is low.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - drive_en=0.
  - Legal code accepted -> DRIVE next cycle: drive_en=1<<code and cur_sel=code, both visible one cycle after the accepting edge. No gap is applied, since nothing is currently driving.
- DRIVE:
  - drive_en holds one-hot(cur_sel).
  - Accepting the same code: no change, no gap.
  - Accepting a different legal code:
    - If GAP_CYCLES=0: drive_en switches directly to the new one-hot after the accepting edge.
    - Otherwise: go to GAP. drive_en=0 and busy=1 for exactly GAP_CYCLES cycles; cur_sel updates to the new code at the accepting edge. Then DRIVE with the new one-hot.
- GAP:
  - A 4-bit down-counter is loaded with GAP_CYCLES-1.
  - At the edge where the counter is 0: state -> DRIVE and drive_en=one-hot(cur_sel).
  - sel_valid is not accepted during GAP.
- Reserved code (bit clear in VALID_MASK, or code >= 24 with the default mask):
  - The handshake still completes (sel_ready as normal).
  - sel_err=1 for the following cycle.
  - State, drive_en and cur_sel are unchanged.
- sel_release:
  - Priority over sel_valid in the same cycle; the offered code is not accepted.
  - From DRIVE or GAP: state -> IDLE at that edge, drive_en=0 next cycle, counter cleared.
  - In IDLE: no effect.
- Invariant: popcount(drive_en) <= 1 in every cycle. Two different sources are never enabled in consecutive cycles when GAP_CYCLES >= 1.

Test Plan:
- Reset, then offer code 4 in IDLE -> accepted at edge k; drive_en=32'h0000_0010 and cur_sel=4 from cycle k+1; busy=0.
- In DRIVE on code 4, offer code 20 (PC) with GAP_CYCLES=1:
  - drive_en=0 and busy=1 for 1 cycle, then 32'h0010_0000.
  - sel_ready=0 during the gap; a valid held through the gap is accepted only afterwards.
- Instantiate with GAP_CYCLES=3, switch from 21 (MDR) to 23 (Cout) -> exactly 3 zero cycles, then drive_en=32'h0080_0000. Re-offer 23 -> no gap, no change.
- In DRIVE on code 2, offer code 27 -> sel_err pulses 1 cycle; drive_en stays 32'h0000_0004; cur_sel stays 2.
- sel_valid=1 (code 9) and sel_release=1 in the same cycle while driving code 2 -> not accepted (sel_ready=0); drive_en=0 next cycle; state IDLE.
- Assert reset during GAP (switching 0 -> 16) -> next cycle drive_en=0, cur_sel=0, busy=0. After reset is released, a new code 17 is accepted with no gap.

Source files
------------

// File: rtl/bus_select_decoder.sv
// bus_select_decoder: accepts a 5-bit bus source code over a valid/ready
// handshake and drives a registered one-hot enable for the 32 bus sources,
// inserting GAP_CYCLES all-zero cycles between two different sources.
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   sel_valid      a select code is offered
//   select_signals offered source code
//   sel_release    stop driving, return to idle (wins over sel_valid)
//   sel_ready      code accepted this cycle (combinational)
//   drive_en       registered one-hot source enable
//   cur_sel        code currently driving, or pending after a gap
//   busy           high while in the break-before-make gap
//   sel_err        one-cycle pulse after a reserved/masked code is accepted
module bus_select_decoder #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [31:0] VALID_MASK = 32'h00FF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel_valid,
  input  logic [4:0]  select_signals,
  input  logic        sel_release,
  output logic        sel_ready,
  output logic [31:0] drive_en,
  output logic [4:0]  cur_sel,
  output logic        busy,
  output logic        sel_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter reload; unused when GAP_CYCLES is 0 (direct switch).
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t      state;
  logic [3:0]  gap_cnt;
  logic        accept;
  logic        legal;
  logic [31:0] new_one_hot;
  logic [31:0] cur_one_hot;

  assign sel_ready   = !reset && !sel_release && (state != GAP);
  assign accept      = sel_valid && sel_ready;
  assign legal       = VALID_MASK[select_signals];
  assign new_one_hot = 32'd1 << select_signals;
  assign cur_one_hot = 32'd1 << cur_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      drive_en <= '0;
      cur_sel  <= '0;
      busy     <= 1'b0;
      sel_err  <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      sel_err <= 1'b0;
      if (sel_release) begin
        if (state != IDLE) begin
          state    <= IDLE;
          drive_en <= '0;
          busy     <= 1'b0;
          gap_cnt  <= '0;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              if (legal) begin
                state    <= DRIVE;
                drive_en <= new_one_hot;
                cur_sel  <= select_signals;
              end else begin
                sel_err <= 1'b1;
              end
            end
          end
          DRIVE: begin
            if (accept) begin
              if (!legal) begin
                sel_err <= 1'b1;
              end else if (select_signals != cur_sel) begin
                cur_sel <= select_signals;
                if (GAP_CYCLES == 0) begin
                  drive_en <= new_one_hot;
                end else begin
                  state    <= GAP;
                  drive_en <= '0;
                  busy     <= 1'b1;
                  gap_cnt  <= GAP_LOAD;
                end
              end
            end
          end
          GAP: begin
            if (gap_cnt == 4'd0) begin
              state    <= DRIVE;
              drive_en <= cur_one_hot;
              busy     <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          default: begin
            state    <= IDLE;
            drive_en <= '0;
            busy     <= 1'b0;
            gap_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_select_decoder.sv
module tb_bus_select_decoder;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  vld;
  logic [1:0]  rel;
  logic [4:0]  code [2];
  logic [1:0]  rdy;
  logic [1:0]  bsy;
  logic [1:0]  err;
  logic [31:0] de [2];
  logic [4:0]  cs [2];

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  typedef struct {
    int          d;
    int          id;
    logic        rdy;
    logic [31:0] de;
    logic        chk_cs;
    logic [4:0]  cs;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bus_select_decoder #(.GAP_CYCLES(1), .VALID_MASK(32'h00FF_FFFF)) u_gap1 (
    .clk(clk), .reset(rst[0]), .sel_valid(vld[0]), .select_signals(code[0]),
    .sel_release(rel[0]), .sel_ready(rdy[0]), .drive_en(de[0]),
    .cur_sel(cs[0]), .busy(bsy[0]), .sel_err(err[0])
  );

  bus_select_decoder #(.GAP_CYCLES(3), .VALID_MASK(32'h00FF_FFFF)) u_gap3 (
    .clk(clk), .reset(rst[1]), .sel_valid(vld[1]), .select_signals(code[1]),
    .sel_release(rel[1]), .sel_ready(rdy[1]), .drive_en(de[1]),
    .cur_sel(cs[1]), .busy(bsy[1]), .sel_err(err[1])
  );

  // One cycle of stimulus for DUT d, plus the outputs expected during it.
  task automatic step(input int d, input logic r, input logic v, input logic [4:0] c,
                      input logic rl, input logic e_rdy, input logic [31:0] e_de,
                      input logic e_chk_cs, input logic [4:0] e_cs,
                      input logic e_busy, input logic e_err);
    exp_t e;
    rst[d]  = r;
    vld[d]  = v;
    code[d] = c;
    rel[d]  = rl;
    step_no++;
    e.d = d; e.id = step_no; e.rdy = e_rdy; e.de = e_de; e.chk_cs = e_chk_cs;
    e.cs = e_cs; e.busy = e_busy; e.err = e_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input int id, input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s got %h expected %h", id, name, got, want);
    end
  endtask

  // Monitor: each cycle the DUT presents outputs, pop and compare.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!$isunknown(de[k])) cmp(0, $sformatf("onehot%0d", k), 32'($countones(de[k]) <= 1), 32'd1);
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.id, "sel_ready", 32'(rdy[e.d]), 32'(e.rdy));
      cmp(e.id, "drive_en", de[e.d], e.de);
      if (e.chk_cs) cmp(e.id, "cur_sel", 32'(cs[e.d]), 32'(e.cs));
      cmp(e.id, "busy", 32'(bsy[e.d]), 32'(e.busy));
      cmp(e.id, "sel_err", 32'(err[e.d]), 32'(e.err));
    end
  end

  initial begin
    rst = 2'b11; vld = '0; rel = '0; code[0] = '0; code[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    // DUT with GAP_CYCLES=1        d  r  v  code   rel rdy de            cs? cs  bsy err
    step(0, 1, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd0,  0, 0);
    step(0, 0, 1, 5'd4,  0, 1, 32'h0000_0000, 1, 5'd0,  0, 0);
    step(0, 0, 1, 5'd20, 0, 1, 32'h0000_0010, 1, 5'd4,  0, 0);
    step(0, 0, 1, 5'd7,  0, 0, 32'h0000_0000, 1, 5'd20, 1, 0);
    step(0, 0, 1, 5'd7,  0, 1, 32'h0010_0000, 1, 5'd20, 0, 0);
    step(0, 0, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd7,  1, 0);
    step(0, 0, 1, 5'd2,  0, 1, 32'h0000_0080, 1, 5'd7,  0, 0);
    step(0, 0, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd2,  1, 0);
    step(0, 0, 1, 5'd27, 0, 1, 32'h0000_0004, 1, 5'd2,  0, 0);
    step(0, 0, 0, 5'd0,  0, 1, 32'h0000_0004, 1, 5'd2,  0, 1);
    step(0, 0, 1, 5'd9,  1, 0, 32'h0000_0004, 1, 5'd2,  0, 0);
    step(0, 0, 0, 5'd0,  1, 0, 32'h0000_0000, 0, 5'd0,  0, 0);
    step(0, 0, 1, 5'd30, 0, 1, 32'h0000_0000, 0, 5'd0,  0, 0);
    step(0, 0, 0, 5'd0,  0, 1, 32'h0000_0000, 0, 5'd0,  0, 1);
    step(0, 0, 1, 5'd0,  0, 1, 32'h0000_0000, 0, 5'd0,  0, 0);
    step(0, 0, 1, 5'd16, 0, 1, 32'h0000_0001, 1, 5'd0,  0, 0);
    step(0, 1, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd16, 1, 0);
    step(0, 0, 1, 5'd17, 0, 1, 32'h0000_0000, 1, 5'd0,  0, 0);
    step(0, 0, 0, 5'd0,  0, 1, 32'h0002_0000, 1, 5'd17, 0, 0);
    step(0, 0, 1, 5'd17, 0, 1, 32'h0002_0000, 1, 5'd17, 0, 0);
    step(0, 0, 0, 5'd0,  0, 1, 32'h0002_0000, 1, 5'd17, 0, 0);
    // DUT with GAP_CYCLES=3
    step(1, 1, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd0,  0, 0);
    step(1, 0, 1, 5'd21, 0, 1, 32'h0000_0000, 1, 5'd0,  0, 0);
    step(1, 0, 1, 5'd23, 0, 1, 32'h0020_0000, 1, 5'd21, 0, 0);
    step(1, 0, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd23, 1, 0);
    step(1, 0, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd23, 1, 0);
    step(1, 0, 0, 5'd0,  0, 0, 32'h0000_0000, 1, 5'd23, 1, 0);
    step(1, 0, 1, 5'd23, 0, 1, 32'h0080_0000, 1, 5'd23, 0, 0);
    step(1, 0, 0, 5'd0,  0, 1, 32'h0080_0000, 1, 5'd23, 0, 0);
    step(1, 0, 1, 5'd5,  0, 1, 32'h0080_0000, 1, 5'd23, 0, 0);
    step(1, 0, 0, 5'd0,  1, 0, 32'h0000_0000, 1, 5'd5,  1, 0);
    step(1, 0, 0, 5'd0,  0, 1, 32'h0000_0000, 0, 5'd0,  0, 0);
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
